axi_rd_arb2: RTL and testbench

- Two-requester AXI read arbiter that shares one AXI read channel pair (AR/R) between two masters, such as instruction fetch and data load.
- It sits in front of the single-outstanding AXI-to-SRAM read bridge and drives that bridge's m_ar*/m_r* interface.
- Round-robin fairness with one transaction in flight at a time; bursts of any length are routed whole to the winner.

---
 rtl/axi_rd_arb2_if.sv | 31 +++
 rtl/axi_rd_arb2.sv | 168 ++++++++++++++++
 tb/tb_axi_rd_arb2.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/axi_rd_arb2_if.sv
// AXI read-channel bundle (AR + R) used for both requester ports and the
// downstream port of axi_rd_arb2.
interface axi_rd_arb2_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  logic [ADDR_W-1:0] araddr;
  logic [ID_W-1:0]   arid;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [ID_W-1:0]   rid;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output araddr, arid, arlen, arsize, arburst, arvalid, rready,
    input  arready, rdata, rid, rresp, rlast, rvalid
  );

  modport slave (
    input  araddr, arid, arlen, arsize, arburst, arvalid, rready,
    output arready, rdata, rid, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_rd_arb2.sv
// Two-requester round-robin AXI read arbiter, one transaction in flight;
// whole bursts are routed to the granted requester by gnt, never by rid.
module axi_rd_arb2 #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic           aclk,
  input  logic           aresetn,
  axi_rd_arb2_if.slave   s0,
  axi_rd_arb2_if.slave   s1,
  axi_rd_arb2_if.master  m
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   gnt_q, gnt_d;
  logic   last_q, last_d;

  logic              ar_valid_s;
  logic              r_ready_s;
  logic              s0_arready_s, s1_arready_s;
  logic              s0_rvalid_s, s1_rvalid_s;
  logic [ADDR_W-1:0] araddr_s;
  logic [ID_W-1:0]   arid_s;
  logic [7:0]        arlen_s;
  logic [2:0]        arsize_s;
  logic [1:0]        arburst_s;
  logic [DATA_W-1:0] rdata_s;

  // last_q resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (s0.arvalid && s1.arvalid) begin
          gnt_d   = ~last_q;
          last_d  = ~last_q;
          state_d = ST_ADDR;
        end else if (s0.arvalid) begin
          gnt_d   = 1'b0;
          last_d  = 1'b0;
          state_d = ST_ADDR;
        end else if (s1.arvalid) begin
          gnt_d   = 1'b1;
          last_d  = 1'b1;
          state_d = ST_ADDR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (ar_valid_s && m.arready) begin
          state_d = ST_DATA;
        end else begin
          state_d = ST_ADDR;
        end
      end
      ST_DATA: begin
        if (m.rvalid && r_ready_s && m.rlast) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DATA;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Handshake gating: only the granted side ever sees a ready/valid.
  always_comb begin
    ar_valid_s   = 1'b0;
    r_ready_s    = 1'b0;
    s0_arready_s = 1'b0;
    s1_arready_s = 1'b0;
    s0_rvalid_s  = 1'b0;
    s1_rvalid_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ar_valid_s = 1'b0;
      end
      ST_ADDR: begin
        if (gnt_q) begin
          ar_valid_s   = s1.arvalid;
          s1_arready_s = m.arready;
        end else begin
          ar_valid_s   = s0.arvalid;
          s0_arready_s = m.arready;
        end
      end
      ST_DATA: begin
        if (gnt_q) begin
          s1_rvalid_s = m.rvalid;
          r_ready_s   = s1.rready;
        end else begin
          s0_rvalid_s = m.rvalid;
          r_ready_s   = s0.rready;
        end
      end
      default: begin
        ar_valid_s = 1'b0;
      end
    endcase
  end

  // AR fields follow gnt regardless of state, so they stay stable while idle.
  always_comb begin
    if (gnt_q) begin
      araddr_s  = s1.araddr;
      arid_s    = s1.arid;
      arlen_s   = s1.arlen;
      arsize_s  = s1.arsize;
      arburst_s = s1.arburst;
    end else begin
      araddr_s  = s0.araddr;
      arid_s    = s0.arid;
      arlen_s   = s0.arlen;
      arsize_s  = s0.arsize;
      arburst_s = s0.arburst;
    end
  end

  assign rdata_s = m.rdata;

  assign m.araddr  = araddr_s;
  assign m.arid    = arid_s;
  assign m.arlen   = arlen_s;
  assign m.arsize  = arsize_s;
  assign m.arburst = arburst_s;
  assign m.arvalid = ar_valid_s;
  assign m.rready  = r_ready_s;

  assign s0.arready = s0_arready_s;
  assign s1.arready = s1_arready_s;
  assign s0.rvalid  = s0_rvalid_s;
  assign s1.rvalid  = s1_rvalid_s;

  assign s0.rdata = rdata_s;
  assign s1.rdata = rdata_s;
  assign s0.rid   = m.rid;
  assign s1.rid   = m.rid;
  assign s0.rresp = m.rresp;
  assign s1.rresp = m.rresp;
  assign s0.rlast = m.rlast;
  assign s1.rlast = m.rlast;

endmodule

// File: tb/tb_axi_rd_arb2.sv
// Directed bench for axi_rd_arb2: per-cycle vector table plus a hand-written
// single-beat read with data broadcast checks.
module tb_axi_rd_arb2;

  logic aclk = 1'b0;
  logic aresetn;
  always #5 aclk = ~aclk;

  axi_rd_arb2_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) s0_if ();
  axi_rd_arb2_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) s1_if ();
  axi_rd_arb2_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) m_if ();

  axi_rd_arb2 #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s0      (s0_if),
    .s1      (s1_if),
    .m       (m_if)
  );

  // stim = {aresetn, s0_arvalid, s1_arvalid, m_arready, m_rvalid, m_rlast, s0_rready, s1_rready}
  // exp  = {m_arvalid, s0_arready, s1_arready, s0_rvalid, s1_rvalid, m_rready}
  typedef struct {
    logic [7:0]  stim;
    logic [5:0]  exp;
    logic [31:0] addr;
  } vec_t;

  localparam int NV = 38;
  vec_t vecs [NV];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] ctl_outs();
    return {m_if.arvalid, s0_if.arready, s1_if.arready,
            s0_if.rvalid, s1_if.rvalid, m_if.rready};
  endfunction

  initial begin
    // Alternating grants with both requesters always valid.
    vecs[0]  = '{8'b1111_0000, 6'b000000, 32'h0};
    vecs[1]  = '{8'b1111_0000, 6'b110000, 32'h10};
    vecs[2]  = '{8'b1111_1111, 6'b000101, 32'h0};
    vecs[3]  = '{8'b1111_0000, 6'b000000, 32'h0};
    vecs[4]  = '{8'b1111_0000, 6'b101000, 32'h20};
    vecs[5]  = '{8'b1111_1111, 6'b000011, 32'h0};
    vecs[6]  = '{8'b1111_0000, 6'b000000, 32'h0};
    vecs[7]  = '{8'b1111_0000, 6'b110000, 32'h10};
    vecs[8]  = '{8'b1111_1111, 6'b000101, 32'h0};
    vecs[9]  = '{8'b1111_0000, 6'b000000, 32'h0};
    vecs[10] = '{8'b1111_0000, 6'b101000, 32'h20};
    vecs[11] = '{8'b1111_1111, 6'b000011, 32'h0};
    // s1 four-beat burst with AR stall, rready gaps and rlast held off.
    vecs[12] = '{8'b1010_0000, 6'b000000, 32'h0};
    vecs[13] = '{8'b1010_0000, 6'b100000, 32'h20};
    vecs[14] = '{8'b1011_0000, 6'b101000, 32'h20};
    vecs[15] = '{8'b1000_1001, 6'b000011, 32'h0};
    vecs[16] = '{8'b1000_1000, 6'b000010, 32'h0};
    vecs[17] = '{8'b1000_1001, 6'b000011, 32'h0};
    vecs[18] = '{8'b1000_1001, 6'b000011, 32'h0};
    vecs[19] = '{8'b1000_1100, 6'b000010, 32'h0};
    vecs[20] = '{8'b1000_1101, 6'b000011, 32'h0};
    vecs[21] = '{8'b1000_1111, 6'b000000, 32'h0};
    // s1 requests while s0 owns the data phase.
    vecs[22] = '{8'b1100_0000, 6'b000000, 32'h0};
    vecs[23] = '{8'b1111_0000, 6'b110000, 32'h10};
    vecs[24] = '{8'b1010_1010, 6'b000101, 32'h0};
    vecs[25] = '{8'b1010_1110, 6'b000101, 32'h0};
    vecs[26] = '{8'b1010_0000, 6'b000000, 32'h0};
    vecs[27] = '{8'b1011_0000, 6'b101000, 32'h20};
    vecs[28] = '{8'b1000_1101, 6'b000011, 32'h0};
    // s0 drops arvalid in ADDR, then re-asserts.
    vecs[29] = '{8'b1100_0000, 6'b000000, 32'h0};
    vecs[30] = '{8'b1001_0000, 6'b010000, 32'h0};
    vecs[31] = '{8'b1100_0000, 6'b100000, 32'h10};
    vecs[32] = '{8'b1101_0000, 6'b110000, 32'h10};
    // Reset during DATA, then a tie that must go to s0.
    vecs[33] = '{8'b0000_0010, 6'b000001, 32'h0};
    vecs[34] = '{8'b1111_0000, 6'b000000, 32'h0};
    vecs[35] = '{8'b1111_0000, 6'b110000, 32'h10};
    vecs[36] = '{8'b1000_1110, 6'b000101, 32'h0};
    vecs[37] = '{8'b1000_0000, 6'b000000, 32'h0};

    aresetn = 1'b0;
    s0_if.araddr = 32'h10; s0_if.arid = 4'h1; s0_if.arlen = 8'h00;
    s0_if.arsize = 3'd2;   s0_if.arburst = 2'b01;
    s0_if.arvalid = 1'b0;  s0_if.rready = 1'b0;
    s1_if.araddr = 32'h20; s1_if.arid = 4'h2; s1_if.arlen = 8'h03;
    s1_if.arsize = 3'd2;   s1_if.arburst = 2'b01;
    s1_if.arvalid = 1'b0;  s1_if.rready = 1'b0;
    m_if.arready = 1'b0;   m_if.rvalid = 1'b0; m_if.rlast = 1'b0;
    m_if.rdata = 32'h0;    m_if.rid = 4'h0;    m_if.rresp = 2'b00;

    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge aclk);
      #1;
      chk($sformatf("idle%0d", k), {26'd0, ctl_outs()}, 32'd0);
    end

    for (int i = 0; i < NV; i++) begin
      @(negedge aclk);
      {aresetn, s0_if.arvalid, s1_if.arvalid, m_if.arready,
       m_if.rvalid, m_if.rlast, s0_if.rready, s1_if.rready} = vecs[i].stim;
      #1;
      chk($sformatf("row%0d_ctl", i), {26'd0, ctl_outs()}, {26'd0, vecs[i].exp});
      if (vecs[i].exp[5]) begin
        chk($sformatf("row%0d_araddr", i), m_if.araddr, vecs[i].addr);
      end
    end

    // Single-beat s0 read at 0x100 with data broadcast.
    @(negedge aclk);
    s0_if.araddr = 32'h100; s0_if.arid = 4'h3; s0_if.arlen = 8'h00;
    s0_if.arvalid = 1'b1;   s1_if.arvalid = 1'b0; m_if.arready = 1'b1;
    m_if.rvalid = 1'b0;     m_if.rlast = 1'b0;
    #1;
    chk("n_arvalid", 32'(m_if.arvalid), 32'd0);
    @(negedge aclk);
    #1;
    chk("n1_arvalid", 32'(m_if.arvalid), 32'd1);
    chk("n1_araddr", m_if.araddr, 32'h100);
    chk("n1_arid", 32'(m_if.arid), 32'h3);
    chk("n1_arlen", 32'(m_if.arlen), 32'h0);
    chk("n1_s0_arready", 32'(s0_if.arready), 32'd1);
    @(negedge aclk);
    s0_if.arvalid = 1'b0; m_if.rvalid = 1'b1; m_if.rdata = 32'hDEADBEEF;
    m_if.rid = 4'h3; m_if.rresp = 2'b00; m_if.rlast = 1'b1;
    s0_if.rready = 1'b1; s1_if.rready = 1'b0;
    #1;
    chk("d_s0_rvalid", 32'(s0_if.rvalid), 32'd1);
    chk("d_s0_rdata", s0_if.rdata, 32'hDEADBEEF);
    chk("d_s0_rid", 32'(s0_if.rid), 32'h3);
    chk("d_s0_rlast", 32'(s0_if.rlast), 32'd1);
    chk("d_s1_rvalid", 32'(s1_if.rvalid), 32'd0);
    chk("d_s1_rdata", s1_if.rdata, 32'hDEADBEEF);
    chk("d_m_rready", 32'(m_if.rready), 32'd1);
    @(negedge aclk);
    m_if.rvalid = 1'b0;
    #1;
    chk("post_idle", {26'd0, ctl_outs()}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
